usb_in_arbiter: RTL and testbench

//  Round-robin arbiter sharing the usb_cdc bulk IN byte stream among N_REQ application sources.
//  It sits between the application requesters and the usb_cdc in_data/in_valid/in_ready interface.
//  A grant is held for one burst of up to MAX_BURST bytes, or until the source marks its last byte.

---
 rtl/usb_in_arbiter.sv | 160 ++++++++++++++++
 tb/tb_usb_in_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_in_arbiter.sv
// Round-robin arbiter that shares the usb_cdc bulk IN byte stream among
// N_REQ application sources. A grant lasts for one burst (up to MAX_BURST
// bytes, a byte marked last, or TIMEOUT idle cycles), so bytes from different
// sources never interleave inside one USB packet. Data is passed through
// combinationally from the granted source; nothing is buffered.
module usb_in_arbiter #(
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 8,
    parameter int TIMEOUT   = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [8*N_REQ-1:0] req_data_i,
    input  logic [N_REQ-1:0]   req_valid_i,
    input  logic [N_REQ-1:0]   req_last_i,
    output logic [N_REQ-1:0]   req_ready_o,
    output logic [7:0]         out_data_o,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [N_REQ-1:0]   grant_o,
    output logic               busy_o
);

    localparam int PTR_W  = $clog2(N_REQ);
    localparam int BCNT_W = $clog2(MAX_BURST + 1);
    localparam int ICNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t            r_state, w_state_next;
    logic [PTR_W-1:0]  r_ptr, w_ptr_next;
    logic [PTR_W-1:0]  r_gidx, w_gidx_next;
    logic [BCNT_W-1:0] r_burst_cnt, w_burst_cnt_next;
    logic [ICNT_W-1:0] r_idle_cnt, w_idle_cnt_next;

    logic [7:0]        w_data_arr [N_REQ];
    logic              w_any_req;
    logic [PTR_W-1:0]  w_pick;
    logic [PTR_W:0]    w_sum;
    logic [PTR_W-1:0]  w_cand;
    logic              w_g_valid;
    logic              w_g_last;
    logic              w_xfer;
    logic              w_release;

    // Split the flat data bus into one byte per requester and decode the grant.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
            assign w_data_arr[gi] = req_data_i[8*gi +: 8];
            assign grant_o[gi]    = (r_state == S_GRANT) && (r_gidx == PTR_W'(gi));
        end
    endgenerate

    assign busy_o    = (r_state == S_GRANT);
    assign w_g_valid = req_valid_i[r_gidx];
    assign w_g_last  = req_last_i[r_gidx];
    assign w_xfer    = out_valid_o & out_ready_i;

    // Rotating search: first valid requester starting at the priority pointer.
    always_comb begin
        w_any_req = 1'b0;
        w_pick    = '0;
        w_sum     = '0;
        w_cand    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_sum = {1'b0, r_ptr} + (PTR_W+1)'(i);
            if (w_sum >= (PTR_W+1)'(N_REQ)) begin
                w_sum = w_sum - (PTR_W+1)'(N_REQ);
            end
            w_cand = w_sum[PTR_W-1:0];
            if (!w_any_req && req_valid_i[w_cand]) begin
                w_any_req = 1'b1;
                w_pick    = w_cand;
            end
        end
    end

    // Pass-through mux: only the granted source sees out_ready_i.
    always_comb begin
        out_data_o  = '0;
        out_valid_o = 1'b0;
        req_ready_o = '0;
        if (r_state == S_GRANT) begin
            out_data_o          = w_data_arr[r_gidx];
            out_valid_o         = w_g_valid;
            req_ready_o[r_gidx] = out_ready_i;
        end
    end

    // Next-state logic: arbitration in IDLE, burst/idle accounting in GRANT.
    always_comb begin
        w_state_next     = r_state;
        w_ptr_next       = r_ptr;
        w_gidx_next      = r_gidx;
        w_burst_cnt_next = r_burst_cnt;
        w_idle_cnt_next  = r_idle_cnt;
        w_release        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_state_next     = S_GRANT;
                    w_gidx_next      = w_pick;
                    w_burst_cnt_next = '0;
                    w_idle_cnt_next  = '0;
                end
            end
            S_GRANT: begin
                if (w_xfer) begin
                    // Last byte and full burst may coincide: still one release.
                    w_burst_cnt_next = r_burst_cnt + BCNT_W'(1);
                    w_idle_cnt_next  = '0;
                    if (w_g_last || (r_burst_cnt == BCNT_W'(MAX_BURST - 1))) begin
                        w_release = 1'b1;
                    end
                end else if (!w_g_valid) begin
                    // Only a silent source counts as idle; backpressure never does.
                    if (r_idle_cnt == ICNT_W'(TIMEOUT - 1)) begin
                        w_release = 1'b1;
                    end else begin
                        w_idle_cnt_next = r_idle_cnt + ICNT_W'(1);
                    end
                end
                if (w_release) begin
                    w_state_next     = S_IDLE;
                    w_burst_cnt_next = '0;
                    w_idle_cnt_next  = '0;
                    if (r_gidx == PTR_W'(N_REQ - 1)) begin
                        w_ptr_next = '0;
                    end else begin
                        w_ptr_next = r_gidx + PTR_W'(1);
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_gidx      <= '0;
            r_burst_cnt <= '0;
            r_idle_cnt  <= '0;
        end else begin
            r_state     <= w_state_next;
            r_ptr       <= w_ptr_next;
            r_gidx      <= w_gidx_next;
            r_burst_cnt <= w_burst_cnt_next;
            r_idle_cnt  <= w_idle_cnt_next;
        end
    end

endmodule

// File: tb/tb_usb_in_arbiter.sv
// Scoreboard bench for usb_in_arbiter: per-source byte queues feed the
// requester ports, expected bytes (source, data) are queued in hand-computed
// order, and a monitor checks every handshake on the output side.
module tb_usb_in_arbiter;

    localparam int N = 4;

    logic           clk_i = 1'b0;
    logic           rst_i;
    logic [8*N-1:0] req_data_i;
    logic [N-1:0]   req_valid_i;
    logic [N-1:0]   req_last_i;
    logic [N-1:0]   req_ready_o;
    logic [7:0]     out_data_o;
    logic           out_valid_o;
    logic           out_ready_i;
    logic [N-1:0]   grant_o;
    logic           busy_o;

    always #5 clk_i = ~clk_i;

    usb_in_arbiter #(.N_REQ(N), .MAX_BURST(8), .TIMEOUT(16)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_data_i  (req_data_i),
        .req_valid_i (req_valid_i),
        .req_last_i  (req_last_i),
        .req_ready_o (req_ready_o),
        .out_data_o  (out_data_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .grant_o     (grant_o),
        .busy_o      (busy_o)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } src_ent_t;

    typedef struct {
        int         src;
        logic [7:0] data;
    } exp_t;

    src_ent_t src_q [N][$];
    exp_t     exp_q [$];
    int       n_checks = 0;
    int       n_fails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic load(input int k, input logic [7:0] base, input int n, input bit last_end);
        for (int i = 0; i < n; i++) begin
            src_ent_t e;
            e.data = base + 8'(i);
            e.last = last_end && (i == n - 1);
            src_q[k].push_back(e);
        end
    endtask

    task automatic expect_seq(input int k, input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.src  = k;
            e.data = base + 8'(i);
            exp_q.push_back(e);
        end
    endtask

    function automatic bit src_empty();
        bit r = 1'b1;
        for (int k = 0; k < N; k++) begin
            if (src_q[k].size() != 0) r = 1'b0;
        end
        return r;
    endfunction

    task automatic wait_drain(input string name);
        int cyc = 0;
        bit done = 1'b0;
        while (!done && cyc < 300) begin
            @(negedge clk_i);
            cyc++;
            done = (exp_q.size() == 0) && src_empty() && !busy_o;
        end
        check(name, 32'(done), 32'd1);
    endtask

    task automatic wait_hs(input string name, input logic [7:0] data);
        int cyc = 0;
        bit hit = 1'b0;
        while (!hit && cyc < 200) begin
            @(negedge clk_i);
            cyc++;
            hit = out_valid_o && out_ready_i && (out_data_o == data);
        end
        check(name, 32'(hit), 32'd1);
    endtask

    task automatic drive_inputs();
        for (int k = 0; k < N; k++) begin
            if (src_q[k].size() > 0) begin
                req_valid_i[k]        = 1'b1;
                req_data_i[8*k +: 8]  = src_q[k][0].data;
                req_last_i[k]         = src_q[k][0].last;
            end else begin
                req_valid_i[k]        = 1'b0;
                req_data_i[8*k +: 8]  = 8'h00;
                req_last_i[k]         = 1'b0;
            end
        end
    endtask

    // Requester model: a byte leaves its queue once it was handshaken.
    initial begin
        logic [N-1:0] hs;
        req_valid_i = '0;
        req_data_i  = '0;
        req_last_i  = '0;
        forever begin
            @(negedge clk_i);
            hs = req_valid_i & req_ready_o;
            @(posedge clk_i);
            #1;
            for (int k = 0; k < N; k++) begin
                if (hs[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
            end
            drive_inputs();
        end
    end

    // Monitor: every output handshake is compared with the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (out_valid_o && out_ready_i) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fails++;
                    $display("FAIL unexpected_xfer: got data 0x%02h grant %b, required no transfer", out_data_o, grant_o);
                end else begin
                    e = exp_q.pop_front();
                    $display("xfer src=%0d data=0x%02h grant=%b", e.src, out_data_o, grant_o);
                    check("xfer_data", 32'(out_data_o), 32'(e.data));
                    check("xfer_grant", 32'(grant_o), 32'(1) << e.src);
                    check("xfer_ready", 32'(req_ready_o), 32'(1) << e.src);
                end
            end
        end
    end

    initial begin
        rst_i       = 1'b1;
        out_ready_i = 1'b1;
        repeat (3) step();
        rst_i = 1'b0;
        @(negedge clk_i);
        check("rst_grant", 32'(grant_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_valid", 32'(out_valid_o), 32'd0);
        check("rst_data", 32'(out_data_o), 32'd0);
        check("rst_ready", 32'(req_ready_o), 32'd0);

        // Test 1: single source, three bytes, last on the third.
        load(0, 8'h01, 3, 1'b1);
        expect_seq(0, 8'h01, 3);
        step();
        check("t1_no_grant_yet", 32'(grant_o), 32'd0);
        step();
        check("t1_grant", 32'(grant_o), 32'b0001);
        check("t1_busy", 32'(busy_o), 32'd1);
        wait_drain("t1_drain");

        // Pointer now 1: source 1 wins over source 0.
        load(0, 8'h05, 1, 1'b1);
        load(1, 8'h06, 1, 1'b1);
        expect_seq(1, 8'h06, 1);
        expect_seq(0, 8'h05, 1);
        wait_drain("t1b_drain");

        // Test 2: reset clears pointer; sources 0 and 2 together.
        rst_i = 1'b1;
        load(0, 8'h21, 2, 1'b1);
        load(2, 8'h41, 2, 1'b1);
        expect_seq(0, 8'h21, 2);
        expect_seq(2, 8'h41, 2);
        step();
        rst_i = 1'b0;
        wait_drain("t2_drain");

        // Test 3: ten bytes without last; burst limit splits them 8 + 2.
        load(1, 8'h11, 10, 1'b0);
        expect_seq(1, 8'h11, 10);
        wait_hs("t3_hs18", 8'h18);
        step();
        check("t3_burst_release", 32'(grant_o), 32'd0);
        step();
        check("t3_regrant", 32'(grant_o), 32'b0010);
        wait_drain("t3_drain");

        // Test 4: long backpressure must not time out.
        out_ready_i = 1'b0;
        load(3, 8'h31, 3, 1'b1);
        expect_seq(3, 8'h31, 3);
        repeat (25) step();
        check("t4_data_mid", 32'(out_data_o), 32'h31);
        repeat (25) step();
        check("t4_grant_held", 32'(grant_o), 32'b1000);
        check("t4_valid_held", 32'(out_valid_o), 32'd1);
        check("t4_data_held", 32'(out_data_o), 32'h31);
        out_ready_i = 1'b1;
        wait_drain("t4_drain");

        // Test 5: source 0 goes silent after two bytes; timeout hands over to 2.
        load(0, 8'hA0, 2, 1'b0);
        load(2, 8'hC0, 1, 1'b1);
        expect_seq(0, 8'hA0, 2);
        expect_seq(2, 8'hC0, 1);
        wait_hs("t5_hsA1", 8'hA1);
        repeat (16) step();
        check("t5_hold_15_idle", 32'(grant_o), 32'b0001);
        step();
        check("t5_timeout_release", 32'(grant_o), 32'd0);
        step();
        check("t5_next_grant", 32'(grant_o), 32'b0100);
        wait_drain("t5_drain");

        // Test 6: reset on byte 4 of an 8-byte burst from source 2.
        load(2, 8'h61, 8, 1'b1);
        expect_seq(2, 8'h61, 4);
        wait_hs("t6_hs64", 8'h64);
        rst_i = 1'b1;
        load(1, 8'h71, 2, 1'b1);
        load(3, 8'h81, 2, 1'b1);
        expect_seq(1, 8'h71, 2);
        expect_seq(2, 8'h65, 4);
        expect_seq(3, 8'h81, 2);
        step();
        check("t6_rst_grant", 32'(grant_o), 32'd0);
        check("t6_rst_valid", 32'(out_valid_o), 32'd0);
        check("t6_rst_busy", 32'(busy_o), 32'd0);
        rst_i = 1'b0;
        wait_drain("t6_drain");

        // Test 7: last coincides with full burst; single release.
        load(0, 8'h91, 8, 1'b1);
        load(1, 8'hB1, 1, 1'b1);
        expect_seq(0, 8'h91, 8);
        expect_seq(1, 8'hB1, 1);
        wait_hs("t7_hs98", 8'h98);
        step();
        check("t7_release", 32'(grant_o), 32'd0);
        step();
        check("t7_next_grant", 32'(grant_o), 32'b0010);
        wait_drain("t7_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
